// File: rtl/imm_lut_loader.sv
// Reloadable 16-entry immediate table with a sequential loader that streams entries from data memory.
// Optional build macro IMM_LUT_CHECKSUM_EN adds an XOR checksum over the loaded words (csum/csum_ok).
module imm_lut_loader #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int DW      = 8,
  parameter int AW      = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  output logic             mem_rd_en,
  output logic [AW-1:0]    mem_addr,
  input  logic [DW-1:0]    mem_rdata,
  input  logic             lk_valid,
  input  logic [IDX_W:0]   lk_in,
  output logic [DW-1:0]    dat_out,
  output logic             dat_valid,
  output logic             busy,
  output logic             done
`ifdef IMM_LUT_CHECKSUM_EN
  ,
  output logic [DW-1:0]    csum,
  output logic             csum_ok
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t              state_reg;
  logic [IDX_W-1:0]    cnt_reg;
  logic [AW-1:0]       base_reg;
  logic                mem_rd_en_reg;
  logic [AW-1:0]       mem_addr_reg;
  logic [DW-1:0]       dat_out_reg;
  logic                dat_valid_reg;
  logic                busy_reg;
  logic                done_reg;

  logic                tbl_wr_en;
  logic [IDX_W-1:0]    tbl_wr_idx;
  logic [ENTRIES-1:0][DW-1:0] tbl_flat;

`ifdef IMM_LUT_CHECKSUM_EN
  logic [DW-1:0]       csum_reg;
  logic                csum_ok_reg;
  logic                csum_pend_reg;
`endif

  function automatic logic [DW-1:0] default_entry(input int idx);
    logic [DW-1:0] v;
    v = '0;
    case (idx)
      0:  v = DW'('h80);
      1:  v = DW'('h0F);
      2:  v = DW'('hEE);
      3:  v = DW'('h10);
      4:  v = DW'('hEB);
      6:  v = DW'('h3D);
      15: v = DW'('hFF);
      default: v = '0;
    endcase
    return v;
  endfunction

  // Read data lags the address by one cycle, so each LOAD cycle commits the previous index.
  always_comb begin
    tbl_wr_en  = 1'b0;
    tbl_wr_idx = '0;
    if (state_reg == LOAD && cnt_reg != '0) begin
      tbl_wr_en  = 1'b1;
      tbl_wr_idx = cnt_reg - IDX_W'(1);
    end else if (state_reg == DRAIN) begin
      tbl_wr_en  = 1'b1;
      tbl_wr_idx = IDX_W'(ENTRIES - 1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_tbl
      logic [DW-1:0] entry_reg;
      always_ff @(posedge Clk) begin
        if (Reset) begin
          entry_reg <= default_entry(gi);
        end else if (tbl_wr_en && tbl_wr_idx == IDX_W'(gi)) begin
          entry_reg <= mem_rdata;
        end
      end
      assign tbl_flat[gi] = entry_reg;
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      base_reg      <= '0;
      mem_rd_en_reg <= 1'b0;
      mem_addr_reg  <= '0;
      dat_out_reg   <= '0;
      dat_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
`ifdef IMM_LUT_CHECKSUM_EN
      csum_reg      <= '0;
      csum_ok_reg   <= 1'b0;
      csum_pend_reg <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
`ifdef IMM_LUT_CHECKSUM_EN
      // The reference word arrives the cycle after DRAIN; compare it then.
      if (csum_pend_reg) begin
        csum_ok_reg   <= (csum_reg == mem_rdata);
        csum_pend_reg <= 1'b0;
      end
`endif
      case (state_reg)
        IDLE: begin
          if (start) begin
            base_reg      <= base_addr;
            cnt_reg       <= '0;
            state_reg     <= LOAD;
            busy_reg      <= 1'b1;
            mem_rd_en_reg <= 1'b1;
            mem_addr_reg  <= base_addr;
`ifdef IMM_LUT_CHECKSUM_EN
            csum_reg      <= '0;
`endif
          end
        end
        LOAD: begin
`ifdef IMM_LUT_CHECKSUM_EN
          if (tbl_wr_en) csum_reg <= csum_reg ^ mem_rdata;
`endif
          if (cnt_reg == IDX_W'(ENTRIES - 1)) begin
            state_reg <= DRAIN;
            done_reg  <= 1'b1;
`ifdef IMM_LUT_CHECKSUM_EN
            mem_rd_en_reg <= 1'b1;
            mem_addr_reg  <= base_reg + AW'(ENTRIES);
`else
            mem_rd_en_reg <= 1'b0;
`endif
          end else begin
            cnt_reg      <= cnt_reg + IDX_W'(1);
            mem_addr_reg <= base_reg + AW'(cnt_reg) + AW'(1);
          end
        end
        DRAIN: begin
          state_reg     <= IDLE;
          busy_reg      <= 1'b0;
          mem_rd_en_reg <= 1'b0;
`ifdef IMM_LUT_CHECKSUM_EN
          csum_reg      <= csum_reg ^ mem_rdata;
          csum_pend_reg <= 1'b1;
`endif
        end
        default: state_reg <= IDLE;
      endcase

      // Table reads are blocked while busy so a half-written table is never observed.
      dat_valid_reg <= 1'b0;
      if (lk_valid) begin
        if (!lk_in[IDX_W]) begin
          dat_out_reg   <= DW'(lk_in[IDX_W-1:0]);
          dat_valid_reg <= 1'b1;
        end else if (!busy_reg) begin
          dat_out_reg   <= tbl_flat[lk_in[IDX_W-1:0]];
          dat_valid_reg <= 1'b1;
        end
      end
    end
  end

  assign mem_rd_en = mem_rd_en_reg;
  assign mem_addr  = mem_addr_reg;
  assign dat_out   = dat_out_reg;
  assign dat_valid = dat_valid_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
`ifdef IMM_LUT_CHECKSUM_EN
  assign csum      = csum_reg;
  assign csum_ok   = csum_ok_reg;
`endif

endmodule

// File: tb/tb_imm_lut_loader.sv
// Directed bench for imm_lut_loader: table-snapshot model checked every cycle plus literal expectations.
module tb_imm_lut_loader;

  logic       Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Reset;
  logic       start;
  logic [7:0] base_addr;
  logic       mem_rd_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       lk_valid;
  logic [4:0] lk_in;
  logic [7:0] dat_out;
  logic       dat_valid;
  logic       busy;
  logic       done;
`ifdef IMM_LUT_CHECKSUM_EN
  logic [7:0] csum;
  logic       csum_ok;
  localparam int RD_WORDS = 17;
`else
  localparam int RD_WORDS = 16;
`endif

  imm_lut_loader dut (
    .Clk(Clk), .Reset(Reset), .start(start), .base_addr(base_addr),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .lk_valid(lk_valid), .lk_in(lk_in), .dat_out(dat_out), .dat_valid(dat_valid),
    .busy(busy), .done(done)
`ifdef IMM_LUT_CHECKSUM_EN
    , .csum(csum), .csum_ok(csum_ok)
`endif
  );

  // Data memory with one-cycle read latency.
  logic [7:0] mem [256];
  always @(posedge Clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a load occupies phases 1..17 after the start cycle; the table becomes a copy of memory when it ends.
  logic [7:0] defaults [16];
  logic [7:0] m_tbl [16];
  int         m_phase;
  logic [7:0] m_base;
  logic       e_valid, e_done, e_rd, e_busy;
  logic [7:0] e_out, e_addr;
  logic       chk_en = 1'b0;

  function automatic int nxt(input int ph, input logic st);
    if (ph == 0) return st ? 1 : 0;
    if (ph == 17) return 0;
    return ph + 1;
  endfunction

  function automatic logic rd_phase(input int ph);
`ifdef IMM_LUT_CHECKSUM_EN
    return ph >= 1 && ph <= 17;
`else
    return ph >= 1 && ph <= 16;
`endif
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      m_phase <= 0;
      for (int i = 0; i < 16; i++) m_tbl[i] <= defaults[i];
      e_valid <= 1'b0; e_out <= 8'h00; e_done <= 1'b0;
      e_rd <= 1'b0; e_addr <= 8'h00; e_busy <= 1'b0;
      chk_en <= 1'b1;
    end else begin
      m_phase <= nxt(m_phase, start);
      if (m_phase == 0 && start) m_base <= base_addr;
      if (m_phase == 17)
        for (int i = 0; i < 16; i++) m_tbl[i] <= mem[8'(m_base + 8'(i))];
      e_busy <= (nxt(m_phase, start) != 0);
      e_done <= (nxt(m_phase, start) == 17);
      e_rd   <= rd_phase(nxt(m_phase, start));
      if (rd_phase(nxt(m_phase, start)))
        e_addr <= ((m_phase == 0 && start) ? base_addr : m_base) + 8'(nxt(m_phase, start) - 1);
      if (lk_valid && !lk_in[4]) begin
        e_out <= {4'h0, lk_in[3:0]}; e_valid <= 1'b1;
      end else if (lk_valid && m_phase == 0) begin
        e_out <= m_tbl[lk_in[3:0]]; e_valid <= 1'b1;
      end else begin
        e_valid <= 1'b0;
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      check("model_dat_valid", dat_valid, e_valid);
      if (e_valid) check("model_dat_out", dat_out, e_out);
      check("model_busy", busy, e_busy);
      check("model_done", done, e_done);
      check("model_mem_rd_en", mem_rd_en, e_rd);
      if (e_rd) check("model_mem_addr", mem_addr, e_addr);
    end
  end

  // Capture of issued read addresses for literal sequence checks.
  logic       cap_en = 1'b0;
  logic [7:0] addr_q [$];
  always @(negedge Clk) if (cap_en && mem_rd_en) addr_q.push_back(mem_addr);

  task automatic lookup(input string name, input logic [4:0] code, input logic exp_v, input logic [7:0] exp_d);
    @(posedge Clk); #1 lk_valid = 1'b1; lk_in = code;
    @(posedge Clk); #1 lk_valid = 1'b0;
    @(negedge Clk);
    check({name, "_valid"}, dat_valid, exp_v);
    if (exp_v) check(name, dat_out, exp_d);
    $display("lookup %s code=%b -> valid=%b dat_out=%02h", name, code, dat_valid, dat_out);
  endtask

  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clk);
      if (done) begin cycles = k; break; end
    end
  endtask

  task automatic begin_load(input logic [7:0] base);
    @(posedge Clk); #1 start = 1'b1; base_addr = base;
    addr_q.delete(); cap_en = 1'b1;
    @(posedge Clk); #1 start = 1'b0;
  endtask

  initial begin
    int n;
    defaults = '{8'h80, 8'h0F, 8'hEE, 8'h10, 8'hEB, 8'h00, 8'h3D, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) mem[8'h20 + i] = 8'(i * 3);
    for (int i = 0; i < 16; i++) mem[8'(8'hF8 + 8'(i))] = 8'hA0 + 8'(i);
    mem_rdata = 8'h00;
    Reset = 1'b1; start = 1'b0; base_addr = 8'h00; lk_valid = 1'b0; lk_in = 5'h00;

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_dat_out", dat_out, 8'h00);
    check("rst_dat_valid", dat_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_mem_rd_en", mem_rd_en, 1'b0);
    check("rst_mem_addr", mem_addr, 8'h00);
    $display("reset: dat_out=%02h busy=%b mem_addr=%02h", dat_out, busy, mem_addr);
    @(posedge Clk); #1 Reset = 1'b0;

    lookup("dflt0", 5'b10000, 1'b1, 8'h80);
    lookup("dflt2", 5'b10010, 1'b1, 8'hEE);
    lookup("dflt15", 5'b11111, 1'b1, 8'hFF);
    lookup("direct7", 5'b00111, 1'b1, 8'h07);

    // Load from 0x20
    begin_load(8'h20);
    wait_done(n);
    check("load1_done_cycle", n, 17);
    @(posedge Clk); #1;
    cap_en = 1'b0;
    check("load1_nreads", addr_q.size(), RD_WORDS);
    if (addr_q.size() >= 16) begin
      check("load1_addr_first", addr_q[0], 8'h20);
      check("load1_addr_last", addr_q[15], 8'h2F);
    end
    $display("load base=20 done after %0d cycles, %0d reads", n, addr_q.size());
    lookup("load1_idx5", 5'b10101, 1'b1, 8'h0F);

    // Wrapping load from 0xF8 with lookups and a second start mid-load
    begin_load(8'hF8);
    lk_valid = 1'b1; lk_in = 5'b10001;
    @(posedge Clk); #1 lk_in = 5'b01001; start = 1'b1; base_addr = 8'h50;
    @(negedge Clk);
    check("busy_table_drop", dat_valid, 1'b0);
    @(posedge Clk); #1 lk_valid = 1'b0; start = 1'b0;
    @(negedge Clk);
    check("busy_direct_valid", dat_valid, 1'b1);
    check("busy_direct", dat_out, 8'h09);
    $display("mid-load: direct lookup dat_out=%02h valid=%b", dat_out, dat_valid);
    wait_done(n);
    check("load2_done_cycle", n, 14);
    @(posedge Clk); #1;
    cap_en = 1'b0;
    check("load2_nreads", addr_q.size(), RD_WORDS);
    if (addr_q.size() >= 16) begin
      check("load2_addr_first", addr_q[0], 8'hF8);
      check("load2_addr_7", addr_q[7], 8'hFF);
      check("load2_addr_8", addr_q[8], 8'h00);
      check("load2_addr_15", addr_q[15], 8'h07);
    end
    $display("load base=F8 reads=%0d", addr_q.size());
    lookup("load2_idx8", 5'b11000, 1'b1, 8'hA8);
    lookup("load2_idx0", 5'b10000, 1'b1, 8'hA0);

    // Reset during load cycle 8
    begin_load(8'h20);
    repeat (7) @(posedge Clk);
    #1 Reset = 1'b1;
    @(negedge Clk);
    check("abort_no_done_pre", done, 1'b0);
    @(posedge Clk); #1 Reset = 1'b0;
    cap_en = 1'b0;
    @(negedge Clk);
    check("abort_busy", busy, 1'b0);
    check("abort_no_done", done, 1'b0);
    $display("abort: busy=%b done=%b", busy, done);
    lookup("abort_idx6", 5'b10110, 1'b1, 8'h3D);
    lookup("abort_idx5", 5'b10101, 1'b1, 8'h00);

`ifdef IMM_LUT_CHECKSUM_EN
    for (int i = 0; i < 16; i++) mem[8'h60 + i] = 8'h01;
    mem[8'h70] = 8'h00;
    begin_load(8'h60);
    wait_done(n);
    check("csum1_done_cycle", n, 17);
    repeat (2) @(negedge Clk);
    check("csum1_value", csum, 8'h00);
    check("csum1_ok", csum_ok, 1'b1);
    $display("checksum good: csum=%02h ok=%b", csum, csum_ok);
    mem[8'h70] = 8'h55;
    begin_load(8'h60);
    wait_done(n);
    repeat (2) @(negedge Clk);
    check("csum2_value", csum, 8'h00);
    check("csum2_ok", csum_ok, 1'b0);
    $display("checksum bad: csum=%02h ok=%b", csum, csum_ok);
`endif

    repeat (3) @(posedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
